// File: rtl/ysyx_24110015_arb_pkg.sv
// ysyx_24110015_arb_pkg: shared types and default widths for the memory arbiter.
package ysyx_24110015_arb_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;
endpackage

// File: rtl/ysyx_24110015_arb_pick.sv
// ysyx_24110015_arb_pick: winner select (1 = LSU); ARB_RR_EN makes ties round-robin, else LSU wins ties.
module ysyx_24110015_arb_pick (
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic winner
);
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  assign winner = (ifu_valid && lsu_valid) ? (RR ? ~last_grant : 1'b1) : lsu_valid;
endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ysyx_24110015_mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight.
// Tie policy set by ARB_RR_EN (round-robin) or fixed LSU priority when undefined.
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d, last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic win;
  ysyx_24110015_arb_pick u_pick (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .last_grant(last_grant_q),
    .winner    (win)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state_q)
      IDLE: if (ifu_req_valid || lsu_req_valid) begin
        ifu_req_ready = ~win;
        lsu_req_ready = win;
        owner_d       = owner_e'(win);
        last_grant_d  = owner_e'(win);
        addr_d        = win ? lsu_req_addr : ifu_req_addr;
        wen_d         = win & lsu_req_wen;
        wdata_d       = win ? lsu_req_wdata : '0;
        wmask_d       = win ? lsu_req_wmask : '0;
        state_d       = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        state_d       = mem_req_ready ? RESP : REQ;
      end
      RESP: begin
        mem_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
        ifu_resp_valid = (owner_q == OWN_IFU) && mem_resp_valid;
        lsu_resp_valid = (owner_q == OWN_LSU) && mem_resp_valid;
        state_d        = (mem_resp_valid && mem_resp_ready) ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign ifu_resp_rdata = mem_resp_rdata;
  assign lsu_resp_rdata = mem_resp_rdata;
endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// tb_ysyx_24110015_mem_arbiter: directed checks of arbitration, payload latch, routing and reset.
module tb_ysyx_24110015_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_req_addr, ifu_resp_rdata;
  logic lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
  logic [3:0] lsu_req_wmask;
  logic mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0] mem_req_wmask;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ysyx_24110015_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Starts in REQ with the request already accepted; leaves the arbiter back in IDLE.
  task automatic finish_txn;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    {ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_req_wen, lsu_resp_ready} = '0;
    {mem_req_ready, mem_resp_valid} = '0;
    ifu_req_addr = '0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wmask = '0; mem_resp_rdata = '0;
    step();
    step();
    mem_resp_valid = 1'b1;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got %b want 000000", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid});
    end
    checks++;
    if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== 69'b0) begin
      errors++;
      $display("FAIL reset_payload: got addr=%h wen=%b wdata=%h wmask=%h want zeros", mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
    end
    rst = 1'b1;
    step();
    checks++;
    if (mem_resp_ready !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_resp: got mem_resp_ready=%b ifu_resp_valid=%b want 0 0", mem_resp_ready, ifu_resp_valid);
    end
    mem_resp_valid = 1'b0;
  endtask
  task automatic test_ifu_read;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0000;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ifu_accept: got ifu_ready=%b lsu_ready=%b want 1 0", ifu_req_ready, lsu_req_ready);
    end
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL ifu_payload: got v=%b addr=%h wen=%b wdata=%h wmask=%h want 1 80000000 0 0 0", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
    end
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0413;
    ifu_resp_ready = 1'b1;
    #1;
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !== 3'b101 || ifu_resp_rdata !== 32'h0000_0413) begin
      errors++;
      $display("FAIL ifu_resp: got ifu_v=%b lsu_v=%b mem_rr=%b rdata=%h want 1 0 1 00000413", ifu_resp_valid, lsu_resp_valid, mem_resp_ready, ifu_resp_rdata);
    end
    step();
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_done: got mem_req_valid=%b ifu_resp_valid=%b want 0 0", mem_req_valid, ifu_resp_valid);
    end
  endtask
  task automatic test_lsu_write;
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h8000_1000;
    lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_wmask = 4'hF;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL lsu_accept: got lsu_ready=%b ifu_ready=%b want 1 0", lsu_req_ready, ifu_req_ready);
    end
    step();
    lsu_req_valid = 1'b0;
    lsu_req_addr = 32'h1234_5678;
    lsu_req_wen = 1'b0;
    lsu_req_wdata = 32'h0;
    lsu_req_wmask = 4'h0;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
        errors++;
        $display("FAIL lsu_payload_stall%0d: got v=%b addr=%h wen=%b wdata=%h wmask=%h want 1 80001000 1 deadbeef f", i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
      end
      checks++;
      if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_no_accept%0d: got ifu_ready=%b lsu_ready=%b want 0 0", i, ifu_req_ready, lsu_req_ready);
      end
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    lsu_resp_ready = 1'b1;
    #1;
    checks++;
    if ({lsu_resp_valid, ifu_resp_valid, mem_resp_ready, ifu_req_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL lsu_resp: got lsu_v=%b ifu_v=%b mem_rr=%b ifu_ready=%b want 1 0 1 0", lsu_resp_valid, ifu_resp_valid, mem_resp_ready, ifu_req_ready);
    end
    step();
    mem_resp_valid = 1'b0;
    lsu_resp_ready = 1'b0;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ifu_waited_accept: got ifu_ready=%b want 1", ifu_req_ready);
    end
    step();
    ifu_req_valid = 1'b0;
    finish_txn();
  endtask
  task automatic test_tie;
    logic [3:0] exp_lsu;
`ifdef ARB_RR_EN
    exp_lsu = 4'b0101;
`else
    exp_lsu = 4'b1111;
`endif
    rst = 1'b0;
    step();
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h0000_0100;
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h0000_0200;
    lsu_req_wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (lsu_req_ready !== exp_lsu[i] || ifu_req_ready !== !exp_lsu[i]) begin
        errors++;
        $display("FAIL tie_grant%0d: got lsu_ready=%b ifu_ready=%b want %b %b", i, lsu_req_ready, ifu_req_ready, exp_lsu[i], !exp_lsu[i]);
      end
      step();
      checks++;
      if (mem_req_addr !== (exp_lsu[i] ? 32'h0000_0200 : 32'h0000_0100)) begin
        errors++;
        $display("FAIL tie_addr%0d: got %h want %h", i, mem_req_addr, exp_lsu[i] ? 32'h0000_0200 : 32'h0000_0100);
      end
      finish_txn();
    end
    lsu_req_valid = 1'b0;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL tie_ifu_after_lsu: got ifu_ready=%b want 1", ifu_req_ready);
    end
    step();
    ifu_req_valid = 1'b0;
    finish_txn();
  endtask
  task automatic test_backpressure;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0010;
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_req_addr = 32'h8000_2000;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hCAFE_0001;
    ifu_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({mem_resp_ready, ifu_resp_valid, lsu_req_ready} !== 3'b010 || ifu_resp_rdata !== 32'hCAFE_0001) begin
        errors++;
        $display("FAIL bp_stall%0d: got mem_rr=%b ifu_v=%b lsu_ready=%b rdata=%h want 0 1 0 cafe0001", i, mem_resp_ready, ifu_resp_valid, lsu_req_ready, ifu_resp_rdata);
      end
      step();
    end
    ifu_resp_ready = 1'b1;
    #1;
    checks++;
    if (mem_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got mem_rr=%b want 1", mem_resp_ready);
    end
    step();
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: got lsu_ready=%b want 1", lsu_req_ready);
    end
    step();
    lsu_req_valid = 1'b0;
    finish_txn();
  endtask
  task automatic test_reset_mid;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0020;
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    ifu_resp_ready = 1'b0;
    #1;
    checks++;
    if (ifu_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_resp: got ifu_v=%b want 1", ifu_resp_valid);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid} !== 6'b0 || mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_idle: got hs=%b addr=%h want 000000 0", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid}, mem_req_addr);
    end
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0030;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reaccept: got ifu_ready=%b want 1", ifu_req_ready);
    end
    step();
    ifu_req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0030) begin
      errors++;
      $display("FAIL mid_new_req: got v=%b addr=%h want 1 80000030", mem_req_valid, mem_req_addr);
    end
    finish_txn();
  endtask
  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_tie();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
